// File: rtl/race_sequencer.sv
// Game-phase controller for the road: countdown, race, crash and end-of-game sequencing,
// button gating toward the speed block, distance integration, fuel, lives and turbo budget.
module race_sequencer #(
  parameter int unsigned STEP_FRAMES  = 30,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned FUEL_MAX     = 255,
  parameter int unsigned BURN_FRAMES  = 30,
  parameter int unsigned FUEL_BONUS   = 40,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned TRACK_LEN    = 20000,
  parameter int unsigned TURBO_FRAMES = 90,
  parameter int unsigned TURBO_COOL   = 150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_button,
  input  logic        gas_button,
  input  logic        brake_button,
  input  logic        turbo_button,
  input  logic        car_collision,
  input  logic        fuel_pickup,
  input  logic [3:0]  road_speed,
  output logic        gas_out,
  output logic        brake_out,
  output logic        turbo_out,
  output logic        stop_road,
  output logic [2:0]  game_state,
  output logic [1:0]  countdown_digit,
  output logic [7:0]  fuel_level,
  output logic [15:0] distance,
  output logic [1:0]  lives_left,
  output logic        crash_blink
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RACE      = 3'd2,
    S_CRASH     = 3'd3,
    S_FINISH    = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam int unsigned CD_FRAMES = 3 * STEP_FRAMES;
  localparam int unsigned FR_W = $clog2(CD_FRAMES + 1);
  // crash_cnt needs bit 2 for the blink even with a tiny CRASH_FRAMES
  localparam int unsigned CR_W = ($clog2(CRASH_FRAMES + 1) < 3) ? 3 : $clog2(CRASH_FRAMES + 1);
  localparam int unsigned BU_W = $clog2(BURN_FRAMES + 1);
  localparam int unsigned TU_W = $clog2(TURBO_FRAMES + 1);
  localparam int unsigned CO_W = $clog2(TURBO_COOL + 1);

  state_t          state_reg;
  logic [FR_W-1:0] frame_cnt_reg;
  logic [CR_W-1:0] crash_cnt_reg;
  logic [BU_W-1:0] burn_cnt_reg;
  logic [TU_W-1:0] turbo_cnt_reg;
  logic [CO_W-1:0] cool_cnt_reg;
  logic            cooldown_reg;
  logic [7:0]      fuel_reg;
  logic [15:0]     dist_reg;
  logic [1:0]      lives_reg;
  logic            coll_latch_reg;
  logic            pick_latch_reg;

  logic        coll_evt, pick_evt, dist_hit, burn_wrap, start_game;
  logic [16:0] dist_sum;
  logic [15:0] dist_next;
  logic [8:0]  fuel_sum, fuel_diff, burn_amt;
  logic [7:0]  fuel_picked, fuel_next;

  assign gas_out    = gas_button & (state_reg == S_RACE) & (fuel_reg != 8'd0);
  assign brake_out  = brake_button & (state_reg == S_RACE);
  assign turbo_out  = turbo_button & gas_out & ~cooldown_reg & (turbo_cnt_reg < TU_W'(TURBO_FRAMES));
  assign stop_road  = (state_reg != S_RACE);
  assign game_state = state_reg;
  assign fuel_level = fuel_reg;
  assign distance   = dist_reg;
  assign lives_left = lives_reg;
  assign crash_blink = (state_reg == S_CRASH) & crash_cnt_reg[2];

  always_comb begin
    countdown_digit = 2'd0;
    if (state_reg == S_COUNTDOWN) begin
      if (frame_cnt_reg < FR_W'(STEP_FRAMES))          countdown_digit = 2'd3;
      else if (frame_cnt_reg < FR_W'(2 * STEP_FRAMES)) countdown_digit = 2'd2;
      else                                             countdown_digit = 2'd1;
    end
  end

  // Next-frame arithmetic, widened so the clamps see the true sum/difference
  always_comb begin
    coll_evt  = coll_latch_reg | car_collision;
    pick_evt  = pick_latch_reg | fuel_pickup;
    dist_sum  = {1'b0, dist_reg} + {13'd0, road_speed};
    dist_hit  = (dist_sum >= 17'(TRACK_LEN));
    dist_next = dist_hit ? 16'(TRACK_LEN) : dist_sum[15:0];
    fuel_sum  = {1'b0, fuel_reg} + 9'(FUEL_BONUS);
    if (!pick_evt)                   fuel_picked = fuel_reg;
    else if (fuel_sum > 9'(FUEL_MAX)) fuel_picked = 8'(FUEL_MAX);
    else                             fuel_picked = fuel_sum[7:0];
    burn_wrap = gas_out & (burn_cnt_reg == BU_W'(BURN_FRAMES - 1));
    burn_amt  = turbo_out ? 9'd2 : 9'd1;
    fuel_diff = {1'b0, fuel_picked} - burn_amt;
    if (!burn_wrap)        fuel_next = fuel_picked;
    else if (fuel_diff[8]) fuel_next = 8'd0;
    else                   fuel_next = fuel_diff[7:0];
    start_game = startOfFrame & start_button &
                 ((state_reg == S_IDLE) | (state_reg == S_FINISH) | (state_reg == S_GAME_OVER));
  end

  always_ff @(posedge clk) begin
    if (reset || start_game) begin
      state_reg      <= reset ? S_IDLE : S_COUNTDOWN;
      frame_cnt_reg  <= '0;
      crash_cnt_reg  <= '0;
      burn_cnt_reg   <= '0;
      turbo_cnt_reg  <= '0;
      cool_cnt_reg   <= '0;
      cooldown_reg   <= 1'b0;
      fuel_reg       <= 8'(FUEL_MAX);
      dist_reg       <= 16'd0;
      lives_reg      <= 2'(LIVES);
      coll_latch_reg <= 1'b0;
      pick_latch_reg <= 1'b0;
    end else if (!startOfFrame) begin
      coll_latch_reg <= coll_latch_reg | car_collision;
      pick_latch_reg <= pick_latch_reg | fuel_pickup;
    end else begin
      coll_latch_reg <= 1'b0;
      pick_latch_reg <= 1'b0;
      case (state_reg)
        S_COUNTDOWN: begin
          if (frame_cnt_reg == FR_W'(CD_FRAMES - 1)) begin
            state_reg     <= S_RACE;
            frame_cnt_reg <= '0;
          end else begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
        S_RACE: begin
          // Turbo budget runs alongside the main race priorities
          if (cooldown_reg) begin
            if (cool_cnt_reg == CO_W'(TURBO_COOL - 1)) begin
              cooldown_reg  <= 1'b0;
              cool_cnt_reg  <= '0;
              turbo_cnt_reg <= '0;
            end else begin
              cool_cnt_reg <= cool_cnt_reg + 1'b1;
            end
          end else if (!turbo_button) begin
            turbo_cnt_reg <= '0;
          end else if (turbo_out) begin
            turbo_cnt_reg <= turbo_cnt_reg + 1'b1;
            if (turbo_cnt_reg == TU_W'(TURBO_FRAMES - 1)) begin
              cooldown_reg <= 1'b1;
              cool_cnt_reg <= '0;
            end
          end
          dist_reg <= dist_next;
          if (dist_hit) begin
            state_reg <= S_FINISH;
          end else if (coll_evt) begin
            lives_reg     <= (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;
            crash_cnt_reg <= '0;
            state_reg     <= (lives_reg <= 2'd1) ? S_GAME_OVER : S_CRASH;
          end else begin
            if (gas_out) burn_cnt_reg <= burn_wrap ? '0 : burn_cnt_reg + 1'b1;
            fuel_reg <= fuel_next;
            if ((fuel_next == 8'd0) && (road_speed == 4'd0)) state_reg <= S_GAME_OVER;
          end
        end
        S_CRASH: begin
          dist_reg <= dist_next;
          if (crash_cnt_reg == CR_W'(CRASH_FRAMES - 1)) begin
            crash_cnt_reg <= '0;
            state_reg     <= S_RACE;
          end else begin
            crash_cnt_reg <= crash_cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed game scenarios plus random play, checked every cycle
// against a frame-level reference model, with literal checkpoints pinning the model.
module tb_race_sequencer;

  localparam int STEP = 30, CRASHF = 60, FMAX = 255, BURN = 30, BONUS = 40;
  localparam int NLIVES = 3, TRACK = 20000, TFR = 90, TCOOL = 150;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, startOfFrame = 1'b0, start_button = 1'b0;
  logic gas_button = 1'b0, brake_button = 1'b0, turbo_button = 1'b0;
  logic car_collision = 1'b0, fuel_pickup = 1'b0;
  logic [3:0] road_speed = 4'd0;
  logic gas_out, brake_out, turbo_out, stop_road, crash_blink;
  logic [2:0] game_state;
  logic [1:0] countdown_digit, lives_left;
  logic [7:0] fuel_level;
  logic [15:0] distance;

  race_sequencer dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_button(start_button),
    .gas_button(gas_button), .brake_button(brake_button), .turbo_button(turbo_button),
    .car_collision(car_collision), .fuel_pickup(fuel_pickup), .road_speed(road_speed),
    .gas_out(gas_out), .brake_out(brake_out), .turbo_out(turbo_out), .stop_road(stop_road),
    .game_state(game_state), .countdown_digit(countdown_digit), .fuel_level(fuel_level),
    .distance(distance), .lives_left(lives_left), .crash_blink(crash_blink)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: phase code, SOF counts since phase entry, plain integer quantities
  int m_st, m_fuel, m_dist, m_lives, m_frame, m_crash, m_burn, m_tcnt, m_cool_left;
  bit m_cl, m_pl;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_gas();
    return gas_button && (m_st == 2) && (m_fuel != 0);
  endfunction

  function automatic bit m_turbo();
    return turbo_button && m_gas() && (m_cool_left == 0) && (m_tcnt < TFR);
  endfunction

  task automatic m_new_game(input int st);
    m_st = st; m_fuel = FMAX; m_dist = 0; m_lives = NLIVES; m_frame = 0; m_crash = 0;
    m_burn = 0; m_tcnt = 0; m_cool_left = 0; m_cl = 0; m_pl = 0;
  endtask

  task automatic model_update();
    bit coll, pick, g, t;
    int spd;
    if (reset) begin
      m_new_game(0);
      return;
    end
    if (!startOfFrame) begin
      m_cl = m_cl | car_collision;
      m_pl = m_pl | fuel_pickup;
      return;
    end
    coll = m_cl | car_collision;
    pick = m_pl | fuel_pickup;
    m_cl = 0; m_pl = 0;
    g = m_gas(); t = m_turbo();
    spd = int'(road_speed);
    case (m_st)
      0, 4, 5: if (start_button) m_new_game(1);
      1: begin
        m_frame++;
        if (m_frame == 3 * STEP) m_st = 2;
      end
      2: begin
        if (m_cool_left > 0) begin
          m_cool_left--;
          if (m_cool_left == 0) m_tcnt = 0;
        end else if (!turbo_button) m_tcnt = 0;
        else if (t) begin
          m_tcnt++;
          if (m_tcnt == TFR) m_cool_left = TCOOL;
        end
        if (m_dist + spd >= TRACK) begin
          m_dist = TRACK; m_st = 4;
        end else begin
          m_dist += spd;
          if (coll) begin
            if (m_lives > 0) m_lives--;
            m_crash = 0;
            m_st = (m_lives == 0) ? 5 : 3;
          end else begin
            if (pick) m_fuel = (m_fuel + BONUS > FMAX) ? FMAX : m_fuel + BONUS;
            if (g) begin
              m_burn++;
              if (m_burn == BURN) begin
                m_burn = 0;
                m_fuel = m_fuel - (t ? 2 : 1);
                if (m_fuel < 0) m_fuel = 0;
              end
            end
            if (m_fuel == 0 && spd == 0) m_st = 5;
          end
        end
      end
      3: begin
        m_dist = (m_dist + spd > TRACK) ? TRACK : m_dist + spd;
        m_crash++;
        if (m_crash == CRASHF) m_st = 2;
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("game_state", game_state, m_st);
      chk("stop_road", stop_road, (m_st != 2));
      chk("countdown_digit", countdown_digit, (m_st == 1) ? 3 - m_frame / STEP : 0);
      chk("fuel_level", fuel_level, m_fuel);
      chk("distance", distance, m_dist);
      chk("lives_left", lives_left, m_lives);
      chk("crash_blink", crash_blink, (m_st == 3) ? (m_crash / 4) % 2 : 0);
      chk("gas_out", gas_out, m_gas());
      chk("brake_out", brake_out, brake_button && (m_st == 2));
      chk("turbo_out", turbo_out, m_turbo());
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic frame(input bit coll, input bit pick);
    bit cs, ps;
    cs = 1'($urandom_range(0, 1));
    ps = 1'($urandom_range(0, 1));
    startOfFrame = 1'b0; car_collision = coll & ~cs; fuel_pickup = pick & ~ps;
    tick();
    startOfFrame = 1'b1; car_collision = coll & cs; fuel_pickup = pick & ps;
    tick();
    startOfFrame = 1'b0; car_collision = 1'b0; fuel_pickup = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
  endtask

  task automatic start_game();
    start_button = 1'b1;
    frame(1'b0, 1'b0);
    start_button = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", game_state, 0);
    chk("rst_stop", stop_road, 1);
    chk("rst_fuel", fuel_level, 255);
    chk("rst_lives", lives_left, 3);
    chk("rst_dist", distance, 0);

    // Game 1: countdown timing, distance integration, finish line
    start_game();
    #1;
    chk("cd_state", game_state, 1);
    chk("cd_digit3", countdown_digit, 3);
    run(29); #1; chk("cd_digit3_end", countdown_digit, 3);
    run(1);  #1; chk("cd_digit2", countdown_digit, 2);
    run(59); #1; chk("cd_digit1", countdown_digit, 1); chk("cd_still", game_state, 1);
    run(1);  #1; chk("race_at_90", game_state, 2);
    road_speed = 4'd5; gas_button = 1'b1;
    run(30); #1; chk("gas30_fuel", fuel_level, 254);
    gas_button = 1'b0;
    run(970);  #1; chk("dist_5000", distance, 5000);
    run(2999); #1; chk("pre_finish", game_state, 2); chk("dist_19995", distance, 19995);
    run(1);    #1; chk("finish_state", game_state, 4); chk("finish_dist", distance, 20000);
    chk("finish_stop", stop_road, 1);

    // Game 2: turbo burn, cooldown, crashes, pickups
    start_game(); #1; chk("restart_dist", distance, 0);
    run(90);
    road_speed = 4'd3; gas_button = 1'b1; turbo_button = 1'b1;
    run(30);  #1; chk("turbo30_fuel", fuel_level, 253);
    run(60);  #1; chk("cool_turbo", turbo_out, 0); chk("cool_gas", gas_out, 1);
    run(149); #1; chk("cool_end_turbo", turbo_out, 0);
    run(1);   #1; chk("turbo_back", turbo_out, 1); chk("fuel_244", fuel_level, 244);
    turbo_button = 1'b0;
    frame(1'b1, 1'b0); #1;
    chk("crash1_lives", lives_left, 2); chk("crash1_state", game_state, 3);
    chk("crash1_gas", gas_out, 0);
    run(59); #1; chk("crash1_hold", game_state, 3);
    run(1);  #1; chk("crash1_end", game_state, 2);
    frame(1'b1, 1'b1); #1; chk("coll_pick_fuel", fuel_level, 244); chk("crash2_lives", lives_left, 1);
    run(60);
    frame(1'b0, 1'b1); #1; chk("pickup_sat", fuel_level, 255);
    frame(1'b1, 1'b0); #1; chk("crash3_state", game_state, 5); chk("crash3_lives", lives_left, 0);

    // Random play across all phases
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0)  gas_button = ~gas_button;
      if ($urandom_range(0, 19) == 0) turbo_button = ~turbo_button;
      brake_button = ($urandom_range(0, 4) == 0);
      road_speed = 4'($urandom_range(0, 10));
      start_button = ($urandom_range(0, 9) == 0);
      frame($urandom_range(0, 119) == 0, $urandom_range(0, 39) == 0);
    end
    start_button = 1'b0; gas_button = 1'b0; turbo_button = 1'b0; brake_button = 1'b0;

    // Reset in CRASH with a pending pickup latch
    reset = 1'b1; tick(); reset = 1'b0;
    start_game(); run(90);
    road_speed = 4'd4; gas_button = 1'b1;
    frame(1'b1, 1'b0); run(5);
    fuel_pickup = 1'b1; tick(); fuel_pickup = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    chk("rc_state", game_state, 0); chk("rc_lives", lives_left, 3);
    chk("rc_fuel", fuel_level, 255); chk("rc_dist", distance, 0); chk("rc_stop", stop_road, 1);

    // Fuel exhaustion at standstill
    start_game(); run(90);
    road_speed = 4'd0; gas_button = 1'b1; turbo_button = 1'b1;
    for (int i = 0; i < 8000 && game_state != 3'd5; i++) frame(1'b0, 1'b0);
    #1;
    chk("drain_state", game_state, 5); chk("drain_fuel", fuel_level, 0);

    chk_en = 1'b0;
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
